// File: rtl/backend_pipe_ctrl.sv
`default_nettype none
//============================================================================
//  Module   : backend_pipe_ctrl
//  Brief    : Central stall/flush sequencer for the backend. In RUN it turns
//             issue-queue, free-list and ROB back-pressure into per-stage
//             pauses. A commit-side flush runs one FLUSH cycle followed by
//             RECOVER_CYCLES cycles of rename-map recovery before the pipe is
//             released. Saturating stall and flush counters are kept.
//  Revision : 1.0  initial release
//----------------------------------------------------------------------------
//  Ports
//    clk, rst                  clock / asynchronous active-low reset
//    rename_allocatable        free list can supply two PRFs
//    rob_full                  ROB cannot take an instruction pair
//    dispatch_req_{alu,lsu,mdu} pair needs the corresponding issue queue
//    {alu,lsu,mdu}_queue_ready issue queue has room for the pair
//    commit_flush_req          flush pulse from commit, with commit_redirect_pc
//    perf_clr                  synchronous clear of the perf counters
//    pause_decode_rename       hold decode->rename registers
//    pause_rename_dispatch     hold rename_dispatch_reg, suppress queue writes
//    fe_pause_req              pause request to the front end
//    flush_frontend/backend    flush strobes, asserted for the FLUSH cycle
//    recover                   restore rename map from the committed map
//    fe_redirect_valid/pc      fetch redirect (pc is the captured flush PC)
//    ctrl_state                FSM state for debug (RUN=0 FLUSH=1 RECOVER=2)
//    perf_stall_iq/rename      saturating stall-cycle counters
//    perf_flush_cnt            saturating count of accepted flushes
//============================================================================
module backend_pipe_ctrl #(
    parameter int RECOVER_CYCLES = 2,
    parameter int PERF_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rename_allocatable,
    input  logic              rob_full,
    input  logic              dispatch_req_alu,
    input  logic              dispatch_req_lsu,
    input  logic              dispatch_req_mdu,
    input  logic              alu_queue_ready,
    input  logic              lsu_queue_ready,
    input  logic              mdu_queue_ready,
    input  logic              commit_flush_req,
    input  logic [31:0]       commit_redirect_pc,
    input  logic              perf_clr,
    output logic              pause_decode_rename,
    output logic              pause_rename_dispatch,
    output logic              fe_pause_req,
    output logic              flush_frontend,
    output logic              flush_backend,
    output logic              recover,
    output logic              fe_redirect_valid,
    output logic [31:0]       fe_redirect_pc,
    output logic [1:0]        ctrl_state,
    output logic [PERF_W-1:0] perf_stall_iq,
    output logic [PERF_W-1:0] perf_stall_rename,
    output logic [15:0]       perf_flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_RECOVER = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    localparam logic [3:0] C_REC_LAST = 4'(RECOVER_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_rec_cnt;
    logic [3:0]  w_rec_cnt_next;
    logic [31:0] r_redirect_pc;
    logic [PERF_W-1:0] r_stall_iq;
    logic [PERF_W-1:0] r_stall_rename;
    logic [15:0] r_flush_cnt;

    logic w_iq_stall;
    logic w_rn_stall;
    logic w_in_run;
    logic w_flush_take;

    assign w_iq_stall = (dispatch_req_alu & ~alu_queue_ready) |
                        (dispatch_req_lsu & ~lsu_queue_ready) |
                        (dispatch_req_mdu & ~mdu_queue_ready);
    assign w_rn_stall = ~rename_allocatable | rob_full;
    assign w_in_run   = (r_state == ST_RUN);
    assign w_flush_take = (w_state_next == ST_FLUSH);

    // Next-state and outputs. A flush request in any legal state restarts the
    // sequence, which also covers a flush landing on the RECOVER->RUN cycle.
    always_comb begin
        w_state_next          = r_state;
        w_rec_cnt_next        = r_rec_cnt;
        pause_decode_rename   = 1'b0;
        pause_rename_dispatch = 1'b0;
        fe_pause_req          = 1'b0;
        flush_frontend        = 1'b0;
        flush_backend         = 1'b0;
        recover               = 1'b0;
        fe_redirect_valid     = 1'b0;

        case (r_state)
            ST_RUN: begin
                pause_rename_dispatch = w_iq_stall;
                pause_decode_rename   = w_iq_stall | w_rn_stall;
                fe_pause_req          = w_iq_stall | w_rn_stall;
                if (commit_flush_req) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush_frontend        = 1'b1;
                flush_backend         = 1'b1;
                fe_redirect_valid     = 1'b1;
                pause_rename_dispatch = 1'b1;
                pause_decode_rename   = 1'b1;
                fe_pause_req          = 1'b1;
                w_state_next          = commit_flush_req ? ST_FLUSH : ST_RECOVER;
                w_rec_cnt_next        = 4'd0;
            end
            ST_RECOVER: begin
                recover               = 1'b1;
                pause_rename_dispatch = 1'b1;
                pause_decode_rename   = 1'b1;
                fe_pause_req          = 1'b1;
                w_rec_cnt_next        = r_rec_cnt + 4'd1;
                if (commit_flush_req) begin
                    w_state_next   = ST_FLUSH;
                    w_rec_cnt_next = 4'd0;
                end else if (r_rec_cnt == C_REC_LAST) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase

        // Reset forces every output low without waiting for a clock edge,
        // including the combinational RUN pauses.
        if (!rst) begin
            pause_decode_rename   = 1'b0;
            pause_rename_dispatch = 1'b0;
            fe_pause_req          = 1'b0;
            flush_frontend        = 1'b0;
            flush_backend         = 1'b0;
            recover               = 1'b0;
            fe_redirect_valid     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_RUN;
            r_rec_cnt     <= 4'd0;
            r_redirect_pc <= 32'd0;
        end else begin
            r_state   <= w_state_next;
            r_rec_cnt <= w_rec_cnt_next;
            if (w_flush_take) begin
                r_redirect_pc <= commit_redirect_pc;
            end
        end
    end

    // Saturating performance counters; clear beats any increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_iq     <= '0;
            r_stall_rename <= '0;
            r_flush_cnt    <= 16'd0;
        end else if (perf_clr) begin
            r_stall_iq     <= '0;
            r_stall_rename <= '0;
            r_flush_cnt    <= 16'd0;
        end else begin
            if (w_in_run && w_iq_stall && (r_stall_iq != '1)) begin
                r_stall_iq <= r_stall_iq + 1'b1;
            end
            if (w_in_run && w_rn_stall && !w_iq_stall && (r_stall_rename != '1)) begin
                r_stall_rename <= r_stall_rename + 1'b1;
            end
            if (w_flush_take && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign fe_redirect_pc    = r_redirect_pc;
    assign ctrl_state        = r_state;
    assign perf_stall_iq     = r_stall_iq;
    assign perf_stall_rename = r_stall_rename;
    assign perf_flush_cnt    = r_flush_cnt;

endmodule
`default_nettype wire
